// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bundle for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    // Requester side: issues start/bin, observes status and result
    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    // Converter side
    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter with saturation and blanking
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_bcd_seq_if.slave      bus
);
    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_q;
    logic [BIN_W-1:0]    shreg_q;
    logic [SCR_W-1:0]    scratch_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sticky_q;
    logic                busy_q;
    logic                done_q;
    logic [SCR_W-1:0]    bcd_q;
    logic                ovf_q;
    logic [DIGITS-1:0]   blank_q;

    logic [SCR_W-1:0]    adj;
    logic [SCR_W-1:0]    scratch_d;
    logic [BIN_W-1:0]    shreg_d;
    logic                sticky_d;
    logic [SCR_W-1:0]    bcd_d;
    logic [DIGITS-1:0]   blank_d;
    logic                zero_above;

    // One double-dabble step plus the saturated result and leading-zero mask seen in FINISH
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_d = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};
        shreg_d   = shreg_q << 1;
        // A bit leaving the top digit means the running value passed 10^DIGITS-1
        sticky_d  = sticky_q | adj[SCR_W-1];

        bcd_d = sticky_q ? {DIGITS{4'd9}} : scratch_q;

        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above & ~sticky_q;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            blank_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shreg_q   <= bus.bin;
                        scratch_q <= '0;
                        sticky_q  <= 1'b0;
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_d;
                    sticky_q  <= sticky_d;
                    cnt_q     <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q   <= bcd_d;
                    ovf_q   <= sticky_q;
                    blank_q <= blank_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.blank    = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed and exhaustive checks of bin_to_bcd_seq in three configurations
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8  ();
    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if82 ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if16 ();

    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3)) u8   (.clk(clk), .rst_n(rst_n), .bus(if8));
    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(2)) u82  (.clk(clk), .rst_n(rst_n), .bus(if82));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start on one instance and wait (bounded) for its done; lat=-1 on timeout
    task automatic run(input int which, input logic [15:0] v, output int lat,
                       output logic [19:0] bcd, output logic ovf, output logic [4:0] blank);
        logic got;
        @(negedge clk);
        case (which)
            0:       begin if8.start  = 1'b1; if8.bin  = v[7:0]; end
            1:       begin if82.start = 1'b1; if82.bin = v[7:0]; end
            default: begin if16.start = 1'b1; if16.bin = v;      end
        endcase
        @(posedge clk);
        #1;
        if8.start = 1'b0; if82.start = 1'b0; if16.start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            case (which)
                0:       got = if8.done;
                1:       got = if82.done;
                default: got = if16.done;
            endcase
        end
        if (!got) lat = -1;
        case (which)
            0:       begin bcd = 20'(if8.bcd);  ovf = if8.overflow;  blank = 5'(if8.blank);  end
            1:       begin bcd = 20'(if82.bcd); ovf = if82.overflow; blank = 5'(if82.blank); end
            default: begin bcd = if16.bcd;      ovf = if16.overflow; blank = if16.blank;     end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.bcd, if8.overflow, if8.blank} !== 17'd0) begin
            errors++;
            $display("FAIL reset_u8: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all zero",
                     if8.busy, if8.done, if8.bcd, if8.overflow, if8.blank);
        end
        checks++;
        if ({if16.busy, if16.done, if16.bcd, if16.overflow, if16.blank} !== 28'd0) begin
            errors++;
            $display("FAIL reset_u16: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all zero",
                     if16.busy, if16.done, if16.bcd, if16.overflow, if16.blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        run(0, 16'd255, lat, b, o, bl);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL lat_255: got %0d clocks, want 9", lat);
        end
        checks++;
        if ({b[11:0], o, bl[2:0]} !== {12'h255, 1'b0, 3'b000}) begin
            errors++; $display("FAIL conv_255: got bcd=%h ovf=%b blank=%b, want 255 0 000", b[11:0], o, bl[2:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if8.done !== 1'b0) begin
            errors++; $display("FAIL done_width: got done=%b one clock later, want 0", if8.done);
        end
    endtask

    task automatic test_digits();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        logic [15:0] vin [4] = '{16'd0, 16'd7, 16'd100, 16'd10};
        logic [11:0] vb  [4] = '{12'h000, 12'h007, 12'h100, 12'h010};
        logic [2:0]  vbl [4] = '{3'b110, 3'b110, 3'b000, 3'b100};
        for (int i = 0; i < 4; i++) begin
            run(0, vin[i], lat, b, o, bl);
            checks++;
            if ({b[11:0], o, bl[2:0]} !== {vb[i], 1'b0, vbl[i]} || lat !== 9) begin
                errors++;
                $display("FAIL digits_%0d: got bcd=%h ovf=%b blank=%b lat=%0d, want %h 0 %b 9",
                         vin[i], b[11:0], o, bl[2:0], lat, vb[i], vbl[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        logic [15:0] vin [5] = '{16'd200, 16'd42, 16'd99, 16'd100, 16'd5};
        logic [7:0]  vb  [5] = '{8'h99, 8'h42, 8'h99, 8'h99, 8'h05};
        logic        vo  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  vbl [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 5; i++) begin
            run(1, vin[i], lat, b, o, bl);
            checks++;
            if ({b[7:0], o, bl[1:0]} !== {vb[i], vo[i], vbl[i]} || lat !== 9) begin
                errors++;
                $display("FAIL ovf_%0d: got bcd=%h ovf=%b blank=%b lat=%0d, want %h %b %b 9",
                         vin[i], b[7:0], o, bl[1:0], lat, vb[i], vo[i], vbl[i]);
            end
        end
    endtask

    task automatic test_hold();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        run(0, 16'd255, lat, b, o, bl);
        @(negedge clk);
        if8.start = 1'b1; if8.bin = 8'd7;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({if8.bcd, if8.busy, if8.done} !== {12'h255, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL hold_c%0d: got bcd=%h busy=%b done=%b, want 255 1 0", c, if8.bcd, if8.busy, if8.done);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({if8.bcd, if8.busy, if8.done} !== {12'h007, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold_done: got bcd=%h busy=%b done=%b, want 007 0 1", if8.bcd, if8.busy, if8.done);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int at   [3] = '{9, 19, 29};
        logic [11:0] exp [3] = '{12'h001, 12'h031, 12'h061};
        ndone = 0;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            if8.start = (j <= 20);
            if8.bin   = 8'(3 * j + 1);
            @(posedge clk);
            #1;
            if (if8.done === 1'b1) begin
                checks++;
                if (ndone >= 3) begin
                    errors++; $display("FAIL b2b_extra: got done at edge %0d, want only 3 dones", j);
                end else if (j !== at[ndone] || if8.bcd !== exp[ndone]) begin
                    errors++;
                    $display("FAIL b2b_%0d: got edge %0d bcd=%h, want edge %0d bcd=%h",
                             ndone, j, if8.bcd, at[ndone], exp[ndone]);
                end
                ndone++;
            end
        end
        if8.start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d dones, want 3", ndone);
        end
    endtask

    task automatic test_abort();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        logic seen;
        @(negedge clk);
        if8.start = 1'b1; if8.bin = 8'd77;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.bcd} !== 14'd0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b bcd=%h, want 0 0 000", if8.busy, if8.done, if8.bcd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (if8.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_nodone: got a done pulse after reset, want none");
        end
        run(0, 16'd123, lat, b, o, bl);
        checks++;
        if ({b[11:0], o, bl[2:0]} !== {12'h123, 1'b0, 3'b000} || lat !== 9) begin
            errors++;
            $display("FAIL abort_next: got bcd=%h ovf=%b blank=%b lat=%0d, want 123 0 000 9", b[11:0], o, bl[2:0], lat);
        end
    endtask

    task automatic test_wide();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        logic [15:0] vin [3] = '{16'd65535, 16'd0, 16'd1000};
        logic [19:0] vb  [3] = '{20'h65535, 20'h00000, 20'h01000};
        logic [4:0]  vbl [3] = '{5'b00000, 5'b11110, 5'b10000};
        for (int i = 0; i < 3; i++) begin
            run(2, vin[i], lat, b, o, bl);
            checks++;
            if ({b, o, bl} !== {vb[i], 1'b0, vbl[i]} || lat !== 17) begin
                errors++;
                $display("FAIL wide_%0d: got bcd=%h ovf=%b blank=%b lat=%0d, want %h 0 %b 17",
                         vin[i], b, o, bl, lat, vb[i], vbl[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        int lat; logic [19:0] b; logic o; logic [4:0] bl;
        logic [11:0] eb;
        logic [2:0]  ebl;
        for (int v = 0; v < 256; v++) begin
            eb  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            ebl = {(v < 100), (v < 10), 1'b0};
            run(0, 16'(v), lat, b, o, bl);
            checks++;
            if ({b[11:0], o, bl[2:0]} !== {eb, 1'b0, ebl} || lat !== 9) begin
                errors++;
                $display("FAIL exh_%0d: got bcd=%h ovf=%b blank=%b lat=%0d, want %h 0 %b 9",
                         v, b[11:0], o, bl[2:0], lat, eb, ebl);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        if8.start  = 1'b0; if8.bin  = '0;
        if82.start = 1'b0; if82.bin = '0;
        if16.start = 1'b0; if16.bin = '0;
        test_reset();
        test_latency();
        test_digits();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_abort();
        test_wide();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
